// File: rtl/column_carry_resolve_pkg.sv
// Shared widths and types for the column carry-resolve stage.
package column_carry_resolve_pkg;

  localparam int unsigned LIMB_W     = 17;
  localparam int unsigned NUM_LIMBS_P = 64;
  localparam int unsigned CARRY_W    = 5;

  typedef logic [LIMB_W-1:0] limb_t;
  typedef logic [LIMB_W+3:0] colsum_t;

endpackage

// File: rtl/column_carry_resolve.sv
// Serial carry resolution: redundant N+4-bit column sums in, normalised N-bit limbs out,
// with one flush limb per frame holding the residual carry.
module column_carry_resolve
  import column_carry_resolve_pkg::*;
#(
  parameter int unsigned N         = LIMB_W,
  parameter int unsigned NUM_LIMBS = NUM_LIMBS_P,
  parameter int unsigned CW        = CARRY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         col_valid_in,
  output logic         col_ready_out,
  input  logic [N+3:0] col_data_in,
  input  logic         col_last_in,
  output logic         limb_valid_out,
  input  logic         limb_ready_in,
  output logic [N-1:0] limb_data_out,
  output logic         limb_last_out,
  output logic         frame_err_out
);

  localparam int unsigned TW   = N + 5;
  localparam int unsigned CNTW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(NUM_LIMBS - 1);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   carry_q, carry_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    data_q, data_d;
  logic            last_q, last_d;
  logic            err_q, err_d;

  logic            out_free;
  logic            accept;
  logic [TW-1:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      carry_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Ready depends only on state and downstream ready, never on col_valid_in.
  always_comb begin
    out_free      = !valid_q || limb_ready_in;
    col_ready_out = (state_q == RUN) && out_free;
    accept        = col_valid_in && col_ready_out;
    sum           = TW'(col_data_in) + TW'(carry_q);

    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;

    case (state_q)
      RUN: begin
        if (accept) begin
          data_d  = sum[N-1:0];
          carry_d = sum[N+CW-1:N];
          valid_d = 1'b1;
          last_d  = 1'b0;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNTW'(1);
          if (col_last_in) begin
            if (cnt_q != CNT_MAX) err_d = 1'b1;
            state_d = FLUSH;
          end
        end else if (out_free) begin
          valid_d = 1'b0;
        end
      end
      FLUSH: begin
        if (out_free) begin
          data_d  = N'(carry_q);
          last_d  = 1'b1;
          valid_d = 1'b1;
          carry_d = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign limb_valid_out = valid_q;
  assign limb_data_out  = data_q;
  assign limb_last_out  = last_q;
  assign frame_err_out  = err_q;

endmodule

// File: tb/tb_column_carry_resolve.sv
// Directed bench: a small N=4/3-limb instance for hand vectors, an N=17 instance for full frames.
module tb_column_carry_resolve;

  logic clk;
  logic rst_n;

  logic       a_col_valid, a_col_ready, a_col_last;
  logic [7:0] a_col_data;
  logic       a_limb_valid, a_limb_ready, a_limb_last, a_err;
  logic [3:0] a_limb_data;

  logic        b_col_valid, b_col_ready, b_col_last;
  logic [20:0] b_col_data;
  logic        b_limb_valid, b_limb_ready, b_limb_last, b_err;
  logic [16:0] b_limb_data;

  int n_cmp;
  int n_err;

  localparam int BW = 17 * 66;

  column_carry_resolve #(.N(4), .NUM_LIMBS(3), .CW(5)) u_small (
    .clk(clk), .rst_n(rst_n),
    .col_valid_in(a_col_valid), .col_ready_out(a_col_ready),
    .col_data_in(a_col_data), .col_last_in(a_col_last),
    .limb_valid_out(a_limb_valid), .limb_ready_in(a_limb_ready),
    .limb_data_out(a_limb_data), .limb_last_out(a_limb_last),
    .frame_err_out(a_err)
  );

  column_carry_resolve #(.N(17), .NUM_LIMBS(64), .CW(5)) u_big (
    .clk(clk), .rst_n(rst_n),
    .col_valid_in(b_col_valid), .col_ready_out(b_col_ready),
    .col_data_in(b_col_data), .col_last_in(b_col_last),
    .limb_valid_out(b_limb_valid), .limb_ready_in(b_limb_ready),
    .limb_data_out(b_limb_data), .limb_last_out(b_limb_last),
    .frame_err_out(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic a_drive(input logic v, input logic [7:0] d, input logic l);
    a_col_valid = v;
    a_col_data  = d;
    a_col_last  = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_drive(1'b0, 8'h00, 1'b0);
    a_limb_ready = 1'b1;
    b_col_valid = 1'b0; b_col_data = '0; b_col_last = 1'b0; b_limb_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data, a_err} !== 7'b0) begin
      n_err++; $display("FAIL reset_small got %b want 0000000", {a_limb_valid, a_limb_last, a_limb_data, a_err});
    end
    n_cmp++;
    if ({b_limb_valid, b_limb_last, b_limb_data, b_err} !== 20'b0) begin
      n_err++; $display("FAIL reset_big got %h want 0", {b_limb_valid, b_limb_last, b_limb_data, b_err});
    end
    n_cmp++;
    if (a_col_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got %b want 1", a_col_ready);
    end
    rst_n = 1'b1;
  endtask

  // 0x1F x3: 31, 32, 33 -> limbs F,0,1, flush 2.
  task automatic test_basic();
    @(negedge clk); a_drive(1'b1, 8'h1F, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data} !== 6'b10_1111) begin
      n_err++; $display("FAIL basic_l0 got %b want 101111", {a_limb_valid, a_limb_last, a_limb_data});
    end
    a_drive(1'b1, 8'h1F, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data} !== 6'b10_0000) begin
      n_err++; $display("FAIL basic_l1 got %b want 100000", {a_limb_valid, a_limb_last, a_limb_data});
    end
    a_drive(1'b1, 8'h1F, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data, a_col_ready} !== 7'b10_0001_0) begin
      n_err++; $display("FAIL basic_l2 got %b want 1000010", {a_limb_valid, a_limb_last, a_limb_data, a_col_ready});
    end
    a_drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data, a_col_ready} !== 7'b11_0010_1) begin
      n_err++; $display("FAIL basic_flush got %b want 1100101", {a_limb_valid, a_limb_last, a_limb_data, a_col_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_err} !== 2'b00) begin
      n_err++; $display("FAIL basic_idle got %b want 00", {a_limb_valid, a_err});
    end
  endtask

  // 0x05,0x13,0x20 -> limbs 5,3,1, flush 2; downstream stalls 5 cycles after limb 5.
  task automatic test_backpressure();
    @(negedge clk); a_drive(1'b1, 8'h05, 1'b0);
    @(negedge clk);
    a_limb_ready = 1'b0;
    a_drive(1'b1, 8'h13, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_limb_valid, a_limb_last, a_limb_data, a_col_ready} !== 7'b10_0101_0) begin
        n_err++; $display("FAIL bp_hold%0d got %b want 1001010", i, {a_limb_valid, a_limb_last, a_limb_data, a_col_ready});
      end
    end
    a_limb_ready = 1'b1;
    #1;
    n_cmp++;
    if (a_col_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release got %b want 1", a_col_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_data} !== 5'b1_0011) begin
      n_err++; $display("FAIL bp_l1 got %b want 10011", {a_limb_valid, a_limb_data});
    end
    a_drive(1'b1, 8'h20, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data} !== 6'b10_0001) begin
      n_err++; $display("FAIL bp_l2 got %b want 100001", {a_limb_valid, a_limb_last, a_limb_data});
    end
    a_drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data, a_err} !== 7'b11_0010_0) begin
      n_err++; $display("FAIL bp_flush got %b want 1100100", {a_limb_valid, a_limb_last, a_limb_data, a_err});
    end
    @(negedge clk);
  endtask

  // Last on beat 2 of 3: 0x10,0x01 -> limbs 0,2, flush 0, sticky error.
  task automatic test_frame_err();
    @(negedge clk); a_drive(1'b1, 8'h10, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_data, a_err} !== 6'b1_0000_0) begin
      n_err++; $display("FAIL ferr_l0 got %b want 100000", {a_limb_valid, a_limb_data, a_err});
    end
    a_drive(1'b1, 8'h01, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data, a_err} !== 7'b10_0010_1) begin
      n_err++; $display("FAIL ferr_set got %b want 1000101", {a_limb_valid, a_limb_last, a_limb_data, a_err});
    end
    a_drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data} !== 6'b11_0000) begin
      n_err++; $display("FAIL ferr_flush got %b want 110000", {a_limb_valid, a_limb_last, a_limb_data});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_err !== 1'b1) begin
      n_err++; $display("FAIL ferr_sticky got %b want 1", a_err);
    end
  endtask

  // Reset after one 0x1F column (carry 1); next frame 3,4,5 must see carry 0.
  task automatic test_reset_midframe();
    @(negedge clk); a_drive(1'b1, 8'h1F, 1'b0);
    @(negedge clk); a_drive(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data, a_err} !== 7'b0) begin
      n_err++; $display("FAIL rst_async got %b want 0000000", {a_limb_valid, a_limb_last, a_limb_data, a_err});
    end
    @(negedge clk); rst_n = 1'b1;
    a_drive(1'b1, 8'h03, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_data} !== 5'b1_0011) begin
      n_err++; $display("FAIL rst_l0 got %b want 10011", {a_limb_valid, a_limb_data});
    end
    a_drive(1'b1, 8'h04, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_data} !== 5'b1_0100) begin
      n_err++; $display("FAIL rst_l1 got %b want 10100", {a_limb_valid, a_limb_data});
    end
    a_drive(1'b1, 8'h05, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_data} !== 5'b1_0101) begin
      n_err++; $display("FAIL rst_l2 got %b want 10101", {a_limb_valid, a_limb_data});
    end
    a_drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({a_limb_valid, a_limb_last, a_limb_data, a_err} !== 7'b11_0000_0) begin
      n_err++; $display("FAIL rst_flush got %b want 1100000", {a_limb_valid, a_limb_last, a_limb_data, a_err});
    end
    @(negedge clk);
  endtask

  // Full 64-column frame; mode 0 = all 13*(2^17-1) at full rate, mode 1 = varied data with stalls.
  task automatic test_full_frame(input int mode);
    logic [BW-1:0] exp_sum, got_sum;
    logic [20:0]   col;
    int idx, nlimb, cyc;
    logic done, bad_last;
    exp_sum = '0; got_sum = '0;
    idx = 0; nlimb = 0; cyc = 0; done = 1'b0; bad_last = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      b_limb_ready = (mode == 0) ? 1'b1 : (cyc % 3 != 1);
      if (idx < 64 && (mode == 0 || cyc % 5 != 2)) begin
        col = (mode == 0) ? 21'(13 * 131071) : 21'((idx * 77777 + 12345) % 2097152);
        if (mode == 1 && idx % 16 == 5) col = 21'h1FFFFF;
        b_col_valid = 1'b1; b_col_data = col; b_col_last = (idx == 63);
      end else begin
        b_col_valid = 1'b0; b_col_data = '0; b_col_last = 1'b0;
      end
      #1;
      if (b_limb_valid && b_limb_ready) begin
        got_sum = got_sum + (BW'(b_limb_data) << (17 * nlimb));
        if (b_limb_last) begin
          done = 1'b1;
          n_cmp++;
          if (b_limb_data >= 17'd32) begin
            n_err++; $display("FAIL full%0d_flush_range got %0d want <32", mode, b_limb_data);
          end
        end else if (nlimb >= 64) begin
          bad_last = 1'b1;
        end
        nlimb++;
      end
      if (b_col_valid && b_col_ready) begin
        exp_sum = exp_sum + (BW'(b_col_data) << (17 * idx));
        idx++;
      end
      cyc++;
    end
    b_col_valid = 1'b0; b_col_last = 1'b0; b_limb_ready = 1'b1;
    n_cmp++;
    if (!done || nlimb != 65 || bad_last) begin
      n_err++; $display("FAIL full%0d_count got %0d limbs done=%b want 65 done=1", mode, nlimb, done);
    end
    n_cmp++;
    if (got_sum !== exp_sum) begin
      n_err++; $display("FAIL full%0d_sum got %h want %h", mode, got_sum[255:0], exp_sum[255:0]);
    end
    n_cmp++;
    if (b_err !== 1'b0) begin
      n_err++; $display("FAIL full%0d_err got %b want 0", mode, b_err);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_frame_err();
    test_reset_midframe();
    test_full_frame(0);
    test_full_frame(1);
    test_full_frame(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
